serial_adder_ctrl: RTL and testbench

//  Bit-serial adder wrapped around a 1-bit full-adder stage.

---
 rtl/serial_adder_ctrl_if.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_serial_adder_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial adder: requester drives start and operands,
// the adder returns busy/done and the registered sum with carry-out.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a_in, b_in, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a_in, b_in, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder, LSB first through one full-adder cell; done WIDTH+1 cycles after start.
// No backpressure: start is only sampled in IDLE, requests while busy/done are dropped.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic fa_a, fa_b, fa_c, s_out, c_out;

   // Full-adder cell fed from the shift-register LSBs and the recirculated carry.
   assign fa_a  = a_sh_q[0];
   assign fa_b  = b_sh_q[0];
   assign fa_c  = carry_q;
   assign s_out = fa_a ^ fa_b ^ fa_c;
   assign c_out = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a_in;
               b_sh_d  = bus.b_in;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_sh_d  = {s_out, s_sh_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = c_out;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               sum_d   = {s_out, s_sh_q[WIDTH-1:1]};
               cout_d  = c_out;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of the serial adder at WIDTH=8 and WIDTH=4 against integer addition.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst8_n = 1'b0;
   logic rst4_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] last8 = '0;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8.slave));
   serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation; optionally pulse start (with other operands) at RUN cycle pulse_at.
   task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int pulse_at);
      logic [8:0] exp;
      int cyc, busy_cnt;
      bit got;
      exp = 9'(a) + 9'(b) + 9'(c);
      @(negedge clk);
      bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.cin = c;
      @(posedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
      check("busy_after_start", 32'(bus8.busy), 1);
      busy_cnt = 1; cyc = 0; got = 0;
      while (!got && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == pulse_at) begin
            bus8.start = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.cin = 1'b1;
         end else begin
            bus8.start = 1'b0;
         end
         if (bus8.done) begin
            got = 1;
            check("busy_low_at_done", 32'(bus8.busy), 0);
         end else begin
            if (bus8.busy) busy_cnt++;
            check("sum_stable_run", 32'({bus8.cout, bus8.sum}), 32'(last8));
         end
      end
      check("done_seen", 32'(got), 1);
      check("latency", 32'(cyc), 8);
      check("busy_cycles", 32'(busy_cnt), 8);
      check("sum8", 32'(bus8.sum), 32'(exp[7:0]));
      check("cout8", 32'(bus8.cout), 32'(exp[8]));
      last8 = exp;
      bus8.start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(bus8.done), 0);
      check("sum_hold_idle", 32'({bus8.cout, bus8.sum}), 32'(last8));
   endtask

   task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic c);
      int cyc;
      @(negedge clk);
      bus4.start = 1'b1; bus4.a_in = a; bus4.b_in = b; bus4.cin = c;
      @(negedge clk);
      bus4.start = 1'b0;
      cyc = 0;
      while (!bus4.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("w4_done_seen", 32'(bus4.done), 1);
      check("w4_result", 32'({bus4.cout, bus4.sum}), 32'(5'(a) + 5'(b) + 5'(c)));
      @(negedge clk);
   endtask

   initial begin
      logic [8:0] exp;
      int pulses, last_done, cyc;
      bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin = 1'b0;
      bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.cin = 1'b0;
      #12;
      check("rst_busy", 32'(bus8.busy), 0);
      check("rst_done", 32'(bus8.done), 0);
      check("rst_sum", 32'(bus8.sum), 0);
      check("rst_cout", 32'(bus8.cout), 0);
      @(negedge clk);
      rst8_n = 1'b1; rst4_n = 1'b1;

      do_op8(8'hFF, 8'h01, 1'b0, -1);
      do_op8(8'h3C, 8'h5A, 1'b1, -1);
      do_op8(8'h10, 8'h20, 1'b0, 3);

      // Reset mid-RUN aborts with no done.
      @(negedge clk);
      bus8.start = 1'b1; bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.cin = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst8_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus8.busy), 0);
      check("abort_done", 32'(bus8.done), 0);
      check("abort_sum", 32'(bus8.sum), 0);
      check("abort_cout", 32'(bus8.cout), 0);
      last8 = '0;
      repeat (2) @(negedge clk);
      check("abort_no_done", 32'(bus8.done), 0);
      rst8_n = 1'b1;
      do_op8(8'h01, 8'h01, 1'b0, -1);

      for (int i = 0; i < 20; i++)
         do_op8(8'($urandom), 8'($urandom), 1'($urandom), -1);

      // Start held high: one result every WIDTH+2 cycles, new operands after each done.
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
      exp = 9'(bus8.a_in) + 9'(bus8.b_in) + 9'(bus8.cin);
      bus8.start = 1'b1;
      pulses = 0; last_done = 0; cyc = 0;
      while (pulses < 5 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (bus8.done) begin
            check("hold_result", 32'({bus8.cout, bus8.sum}), 32'(exp));
            if (pulses > 0) check("hold_period", 32'(cyc - last_done), 10);
            last_done = cyc;
            pulses++;
            last8 = exp;
            bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
            exp = 9'(bus8.a_in) + 9'(bus8.b_in) + 9'(bus8.cin);
         end else begin
            check("hold_stable", 32'({bus8.cout, bus8.sum}), 32'(last8));
         end
      end
      check("hold_pulses", 32'(pulses), 5);
      bus8.start = 1'b0;

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               do_op4(4'(a), 4'(b), 1'(c));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
